// File: rtl/exe_pipe.sv
// exe_pipe: two-stage execute back end for a MIPS subset.
//   E1: decode, operand read with forwarding, ALU, branch compare, target compute.
//   E2: data memory read/write and register writeback; all outputs are E2 registers.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        instruction handshake (in_ready = !redirect_valid)
//   in_inst, in_pc           instruction word and its byte address
//   redirect_valid/_target   taken beq/j in E2, new fetch address
//   wb_valid/_addr/_data     register write occurring this cycle
//   st_valid/_addr/_data     data memory store occurring this cycle
//   illegal                  unsupported instruction in E2
module exe_pipe #(
  parameter int unsigned DW         = 32,
  parameter int unsigned NREG       = 32,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_inst,
  input  logic [31:0]                   in_pc,
  output logic                          redirect_valid,
  output logic [31:0]                   redirect_target,
  output logic                          wb_valid,
  output logic [4:0]                    wb_addr,
  output logic [DW-1:0]                 wb_data,
  output logic                          st_valid,
  output logic [$clog2(DMEM_DEPTH)-1:0] st_addr,
  output logic [DW-1:0]                 st_data,
  output logic                          illegal
);

  localparam int unsigned AW = $clog2(DMEM_DEPTH);
  localparam int unsigned RW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] dmem [DMEM_DEPTH];

  // E1 pipeline register
  logic        e1_valid;
  logic [31:0] e1_inst;
  logic [31:0] e1_pc;

  // E1 field decode
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        shamt_unused;

  assign op           = e1_inst[31:26];
  assign rs           = e1_inst[25:21];
  assign rt           = e1_inst[20:16];
  assign rd           = e1_inst[15:11];
  assign funct        = e1_inst[5:0];
  assign imm          = e1_inst[15:0];
  assign shamt_unused = ^e1_inst[10:6];

  // Operands: out-of-range indices read 0; E2 writeback bypasses the regfile
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;

  always_comb begin
    rs_val = '0;
    if (32'(rs) < NREG) begin
      if (wb_valid && (wb_addr == rs)) rs_val = wb_data;
      else                             rs_val = regs[rs[RW-1:0]];
    end
  end

  always_comb begin
    rt_val = '0;
    if (32'(rt) < NREG) begin
      if (wb_valid && (wb_addr == rt)) rt_val = wb_data;
      else                             rt_val = regs[rt[RW-1:0]];
    end
  end

  // E1 execute: results that become the E2 registers at the next edge
  logic [DW-1:0] imm_s;
  logic [DW-1:0] imm_z;
  logic [31:0]   pc4;
  logic [31:0]   br_target;
  logic [31:0]   j_target;
  logic [DW-1:0] alu;
  logic [4:0]    dest;
  logic          writes;
  logic          n_wb_valid;
  logic [4:0]    n_wb_addr;
  logic          n_load;
  logic          n_st_valid;
  logic          n_redir;
  logic [31:0]   n_target;
  logic          n_illegal;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ld_val;

  assign imm_s     = DW'($signed(imm));
  assign imm_z     = DW'(imm);
  assign pc4       = e1_pc + 32'd4;
  assign br_target = pc4 + (32'($signed(imm)) << 2);
  assign j_target  = {pc4[31:28], e1_inst[25:0], 2'b00};

  always_comb begin
    alu        = '0;
    dest       = 5'd0;
    writes     = 1'b0;
    n_load     = 1'b0;
    n_st_valid = 1'b0;
    n_redir    = 1'b0;
    n_target   = '0;
    n_illegal  = 1'b0;
    // A taken transfer in E2 squashes the E1 occupant
    if (e1_valid && !redirect_valid) begin
      case (op)
        OP_RTYPE: begin
          dest   = rd;
          writes = 1'b1;
          case (funct)
            FN_ADD:  alu = rs_val + rt_val;
            FN_SUB:  alu = rs_val - rt_val;
            FN_AND:  alu = rs_val & rt_val;
            FN_OR:   alu = rs_val | rt_val;
            FN_SLT:  alu = DW'($signed(rs_val) < $signed(rt_val));
            default: begin
              writes    = 1'b0;
              n_illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI: begin
          alu    = rs_val + imm_s;
          dest   = rt;
          writes = 1'b1;
        end
        OP_ORI: begin
          alu    = rs_val | imm_z;
          dest   = rt;
          writes = 1'b1;
        end
        OP_LW: begin
          alu    = rs_val + imm_s;
          dest   = rt;
          writes = 1'b1;
          n_load = 1'b1;
        end
        OP_SW: begin
          alu        = rs_val + imm_s;
          n_st_valid = 1'b1;
        end
        OP_BEQ: begin
          if (rs_val == rt_val) begin
            n_redir  = 1'b1;
            n_target = br_target;
          end
        end
        OP_J: begin
          n_redir  = 1'b1;
          n_target = j_target;
        end
        default: n_illegal = 1'b1;
      endcase
    end
  end

  assign n_wb_valid = writes && (dest != 5'd0) && (32'(dest) < NREG);
  assign n_wb_addr  = n_wb_valid ? dest : 5'd0;
  assign mem_addr   = alu[AW-1:0];
  // Store in E2 to the same word is forwarded to a load leaving E1
  assign ld_val     = (st_valid && (st_addr == mem_addr)) ? st_data : dmem[mem_addr];

  assign in_ready = !redirect_valid;

  // Pipeline, output and register-file state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_valid        <= 1'b0;
      e1_inst         <= '0;
      e1_pc           <= '0;
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
      wb_valid        <= 1'b0;
      wb_addr         <= '0;
      wb_data         <= '0;
      st_valid        <= 1'b0;
      st_addr         <= '0;
      st_data         <= '0;
      illegal         <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      e1_valid <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        e1_inst <= in_inst;
        e1_pc   <= in_pc;
      end
      redirect_valid  <= n_redir;
      redirect_target <= n_target;
      illegal         <= n_illegal;
      wb_valid        <= n_wb_valid;
      wb_addr         <= n_wb_addr;
      wb_data         <= !n_wb_valid ? '0 : (n_load ? ld_val : alu);
      st_valid        <= n_st_valid;
      st_addr         <= n_st_valid ? mem_addr : '0;
      st_data         <= n_st_valid ? rt_val : '0;
      if (wb_valid) regs[wb_addr[RW-1:0]] <= wb_data;
    end
  end

  // Data memory is not reset
  always_ff @(posedge clk) begin
    if (st_valid) dmem[st_addr] <= st_data;
  end

endmodule

// File: tb/tb_exe_pipe.sv
// Directed-vector bench for exe_pipe: default instance plus a DW=16/NREG=8/DMEM_DEPTH=16 instance.
module tb_exe_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        in_valid, in_ready, redirect_valid, wb_valid, st_valid, illegal;
  logic [31:0] in_inst, in_pc, redirect_target;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, st_data;
  logic [7:0]  st_addr;

  // Narrow instance
  logic        s_in_valid, s_in_ready, s_redirect_valid, s_wb_valid, s_st_valid, s_illegal;
  logic [31:0] s_in_inst, s_in_pc, s_redirect_target;
  logic [4:0]  s_wb_addr;
  logic [15:0] s_wb_data, s_st_data;
  logic [3:0]  s_st_addr;

  exe_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .illegal(illegal)
  );

  exe_pipe #(.DW(16), .NREG(8), .DMEM_DEPTH(16)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_inst(s_in_inst), .in_pc(s_in_pc),
    .redirect_valid(s_redirect_valid), .redirect_target(s_redirect_target),
    .wb_valid(s_wb_valid), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
    .st_valid(s_st_valid), .st_addr(s_st_addr), .st_data(s_st_data),
    .illegal(s_illegal)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic s_issue(input logic [31:0] inst);
    s_in_valid = 1'b1;
    s_in_inst  = inst;
    step();
    s_in_valid = 1'b0;
  endtask

  task automatic chk_wb(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, ".wb_addr"},  64'(wb_addr),  64'(a));
    check({tag, ".wb_data"},  64'(wb_data),  64'(d));
  endtask

  task automatic chk_s_wb(input string tag, input logic [4:0] a, input logic [15:0] d);
    check({tag, ".wb_valid"}, 64'(s_wb_valid), 64'd1);
    check({tag, ".wb_addr"},  64'(s_wb_addr),  64'(a));
    check({tag, ".wb_data"},  64'(s_wb_data),  64'(d));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;   in_inst = '0;   in_pc = '0;
    s_in_valid = 1'b0; s_in_inst = '0; s_in_pc = '0;
    step();
    step();
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.redirect", 64'(redirect_valid), 64'd0);
    check("rst.target",   64'(redirect_target), 64'd0);
    check("rst.wb_valid", 64'(wb_valid), 64'd0);
    check("rst.wb_data",  64'(wb_data), 64'd0);
    check("rst.st_valid", 64'(st_valid), 64'd0);
    check("rst.illegal",  64'(illegal), 64'd0);
    rst = 1'b0;

    // Forwarding chain, then store / load / load-use
    issue(i_type(6'h08, 5'd0, 5'd1, 16'd5), 32'h0);   // addi r1,r0,5
    issue(i_type(6'h08, 5'd1, 5'd2, 16'd3), 32'h4);   // addi r2,r1,3
    chk_wb("fwd.r1", 5'd1, 32'd5);
    issue(r_type(5'd2, 5'd1, 5'd3, 6'h22), 32'h8);    // sub r3,r2,r1
    chk_wb("fwd.r2", 5'd2, 32'd8);
    issue(i_type(6'h2B, 5'd0, 5'd2, 16'd4), 32'hC);   // sw r2,4(r0)
    chk_wb("fwd.r3", 5'd3, 32'd3);
    issue(i_type(6'h23, 5'd0, 5'd4, 16'd4), 32'h10);  // lw r4,4(r0)
    check("sw.st_valid", 64'(st_valid), 64'd1);
    check("sw.st_addr",  64'(st_addr),  64'd4);
    check("sw.st_data",  64'(st_data),  64'd8);
    check("sw.wb_valid", 64'(wb_valid), 64'd0);
    issue(r_type(5'd4, 5'd4, 5'd5, 6'h20), 32'h14);   // add r5,r4,r4
    chk_wb("lw.r4", 5'd4, 32'd8);
    check("lw.st_valid", 64'(st_valid), 64'd0);
    idle();
    chk_wb("ldfwd.r5", 5'd5, 32'd16);

    // slt / ori / and
    issue(i_type(6'h08, 5'd0, 5'd9, 16'hFFFD), 32'h20);  // addi r9,r0,-3
    issue(r_type(5'd9, 5'd1, 5'd10, 6'h2A), 32'h24);     // slt r10,r9,r1
    chk_wb("addi.neg", 5'd9, 32'hFFFF_FFFD);
    issue(i_type(6'h0D, 5'd0, 5'd11, 16'h8000), 32'h28); // ori r11,r0,0x8000
    chk_wb("slt", 5'd10, 32'd1);
    issue(r_type(5'd9, 5'd2, 5'd12, 6'h24), 32'h2C);     // and r12,r9,r2
    chk_wb("ori.zext", 5'd11, 32'h0000_8000);
    idle();
    chk_wb("and", 5'd12, 32'd8);

    // Taken beq squashes the following addi r6
    issue(i_type(6'h04, 5'd1, 5'd1, 16'd2), 32'h100);    // beq r1,r1,+2
    issue(i_type(6'h08, 5'd0, 5'd6, 16'd9), 32'h104);    // addi r6,r0,9
    check("beq.redirect", 64'(redirect_valid), 64'd1);
    check("beq.target",   64'(redirect_target), 64'h10C);
    check("beq.in_ready", 64'(in_ready), 64'd0);
    check("beq.wb_valid", 64'(wb_valid), 64'd0);
    issue(i_type(6'h08, 5'd0, 5'd7, 16'd1), 32'h10C);    // offered while in_ready=0
    check("squash.wb_valid", 64'(wb_valid), 64'd0);
    check("squash.redirect", 64'(redirect_valid), 64'd0);
    check("squash.in_ready", 64'(in_ready), 64'd1);
    issue(i_type(6'h08, 5'd0, 5'd7, 16'd1), 32'h10C);    // addi r7,r0,1
    check("refused.wb_valid", 64'(wb_valid), 64'd0);
    issue(r_type(5'd6, 5'd0, 5'd8, 6'h20), 32'h110);     // add r8,r6,r0
    chk_wb("after.r7", 5'd7, 32'd1);
    idle();
    chk_wb("r6.untouched", 5'd8, 32'd0);

    // Not-taken beq
    issue(i_type(6'h04, 5'd1, 5'd2, 16'd2), 32'h120);    // beq r1,r2
    idle();
    check("bne.redirect", 64'(redirect_valid), 64'd0);
    check("bne.in_ready", 64'(in_ready), 64'd1);

    // Jump and illegal opcode
    issue({6'h02, 26'h40}, 32'h200);
    idle();
    check("j.redirect", 64'(redirect_valid), 64'd1);
    check("j.target",   64'(redirect_target), 64'h100);
    idle();
    check("j.oneshot",  64'(redirect_valid), 64'd0);
    issue(32'hFC21_0004, 32'h300);
    idle();
    check("ill.illegal",  64'(illegal), 64'd1);
    check("ill.wb_valid", 64'(wb_valid), 64'd0);
    check("ill.st_valid", 64'(st_valid), 64'd0);
    check("ill.redirect", 64'(redirect_valid), 64'd0);
    idle();
    check("ill.oneshot",  64'(illegal), 64'd0);

    // Asynchronous reset while add r3 sits in E2
    issue(r_type(5'd1, 5'd2, 5'd3, 6'h20), 32'h400);     // add r3,r1,r2
    idle();
    chk_wb("pre_rst.r3", 5'd3, 32'd13);
    #2 rst = 1'b1;
    #1;
    check("arst.wb_valid", 64'(wb_valid), 64'd0);
    check("arst.wb_data",  64'(wb_data), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    issue(r_type(5'd0, 5'd0, 5'd5, 6'h20), 32'h0);       // add r5,r0,r0
    check("post_rst.wb_valid", 64'(wb_valid), 64'd0);
    issue(r_type(5'd3, 5'd5, 5'd13, 6'h20), 32'h4);      // add r13,r3,r5
    chk_wb("post_rst.r5", 5'd5, 32'd0);
    idle();
    chk_wb("regs_cleared", 5'd13, 32'd0);

    // Narrow instance: DW=16, NREG=8, DMEM_DEPTH=16
    s_issue(i_type(6'h08, 5'd0, 5'd1, 16'hFFFF));        // addi r1,r0,-1
    s_issue(i_type(6'h08, 5'd0, 5'd9, 16'd7));           // addi r9,r0,7 (dropped)
    chk_s_wb("s.r1", 5'd1, 16'hFFFF);
    s_issue(i_type(6'h2B, 5'd0, 5'd1, 16'd20));          // sw r1,20(r0)
    check("s.r9.wb_valid", 64'(s_wb_valid), 64'd0);
    s_issue(r_type(5'd9, 5'd1, 5'd2, 6'h20));            // add r2,r9,r1
    check("s.st_valid", 64'(s_st_valid), 64'd1);
    check("s.st_addr",  64'(s_st_addr), 64'd4);
    check("s.st_data",  64'(s_st_data), 64'hFFFF);
    s_issue(r_type(5'd1, 5'd1, 5'd3, 6'h20));            // add r3,r1,r1
    chk_s_wb("s.r9_reads0", 5'd2, 16'hFFFF);
    step();
    chk_s_wb("s.wrap", 5'd3, 16'hFFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
